// File: rtl/coproc_sequencer.sv
// rtl/coproc_sequencer.sv - vector coprocessor sequencer: BRAM handoff, HLS handshake, result routing, watchdog
module coproc_sequencer #(
    parameter int RESULT_W       = 32,
    parameter int TX_BYTES       = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_ready,
    input  logic                cmd,
    input  logic                out_mode,
    input  logic                disable_screen,
    output logic                bram_grant_hls,
    output logic                hls_op,
    output logic                ap_start,
    input  logic                ap_ready,
    input  logic                ap_done,
    input  logic [RESULT_W-1:0] ap_return,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic [RESULT_W-1:0] disp_value,
    output logic                disp_valid,
    output logic                busy,
    output logic                err_timeout,
    output logic                cmd_dropped
);

    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IDX_W = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TX_BYTES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GRANT    = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_OUT_DISP = 3'd4;
    localparam logic [2:0] S_TX_SEND  = 3'd5;
    localparam logic [2:0] S_TX_GAP   = 3'd6;
    localparam logic [2:0] S_TX_WAIT  = 3'd7;

    logic [2:0]          state;
    logic                mode_q;
    logic [RESULT_W-1:0] result_q;
    logic [WD_W-1:0]     wd_cnt;
    logic [IDX_W-1:0]    idx;
    logic [RESULT_W-1:0] result_shifted;

    // Grant and start derive from state so the async reset drops them without a clock edge.
    assign busy           = (state != S_IDLE);
    assign bram_grant_hls = (state == S_GRANT) || (state == S_START) || (state == S_WAIT);
    assign ap_start       = (state == S_START);

    // Byte 0 on the wire is the most significant byte of the result.
    always_comb begin
        result_shifted = result_q >> (8 * (TX_BYTES - 1 - int'(idx)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_q      <= 1'b0;
            hls_op      <= 1'b0;
            result_q    <= '0;
            wd_cnt      <= '0;
            idx         <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            disp_value  <= '0;
            disp_valid  <= 1'b0;
            err_timeout <= 1'b0;
            cmd_dropped <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            disp_valid  <= 1'b0;
            cmd_dropped <= cmd_ready && ((state != S_IDLE) || disable_screen);
            case (state)
                S_IDLE: begin
                    if (cmd_ready && !disable_screen) begin
                        hls_op      <= cmd;
                        mode_q      <= out_mode;
                        err_timeout <= 1'b0;
                        wd_cnt      <= '0;
                        idx         <= '0;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: state <= S_START;
                S_START: begin
                    if (ap_ready && ap_done) begin
                        result_q <= ap_return;
                        idx      <= '0;
                        state    <= mode_q ? S_TX_SEND : S_OUT_DISP;
                    end else if (wd_cnt == WD_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (ap_ready) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A result arriving on the last watchdog cycle still wins over the abort.
                    if (ap_done) begin
                        result_q <= ap_return;
                        idx      <= '0;
                        state    <= mode_q ? S_TX_SEND : S_OUT_DISP;
                    end else if (wd_cnt == WD_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_OUT_DISP: begin
                    disp_value <= result_q;
                    disp_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                S_TX_SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= result_shifted[7:0];
                        tx_start <= 1'b1;
                        state    <= S_TX_GAP;
                    end
                end
                S_TX_GAP: state <= S_TX_WAIT;
                S_TX_WAIT: begin
                    if (!tx_busy) begin
                        if (idx == IDX_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_TX_SEND;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coproc_sequencer.sv
// tb/tb_coproc_sequencer.sv - scoreboard bench for coproc_sequencer with HLS and UART models
module tb_coproc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_ready = 1'b0, cmd = 1'b0, out_mode = 1'b0, disable_screen = 1'b0;
    logic        bram_grant_hls, hls_op, ap_start;
    logic        ap_ready = 1'b0, ap_done = 1'b0;
    logic [31:0] ap_return = '0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [31:0] disp_value;
    logic        disp_valid, busy, err_timeout, cmd_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_disp[$];
    logic [7:0]  exp_tx[$];

    int          ready_dly = 3;
    int          done_dly  = 7;
    bit          same_cycle = 0;
    logic [31:0] ret_val = '0;
    int          tx_count = 0;

    coproc_sequencer #(.RESULT_W(32), .TX_BYTES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_ready(cmd_ready), .cmd(cmd), .out_mode(out_mode),
        .disable_screen(disable_screen), .bram_grant_hls(bram_grant_hls), .hls_op(hls_op),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_return(ap_return),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .disp_value(disp_value),
        .disp_valid(disp_valid), .busy(busy), .err_timeout(err_timeout), .cmd_dropped(cmd_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor, HLS core model and UART transmitter model share one negedge process.
    int  hls_phase = 0;
    int  hcnt = 0;
    int  busy_cnt = 0;
    bit  start_prev = 0;
    always @(negedge clk) begin
        if (ap_ready) chk("ap_start_drop_after_ready", ap_start, 0);
        if (ap_start) chk("grant_during_start", bram_grant_hls, 1);
        if (disp_valid) begin
            if (exp_disp.size() == 0) chk("unexpected_disp_valid", disp_value, 32'hxxxx_xxxx);
            else chk("disp_value", disp_value, exp_disp.pop_front());
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (tx_start) begin
            tx_count++;
            chk("tx_start_while_busy", tx_busy, 0);
            if (exp_tx.size() == 0) chk("unexpected_tx_start", tx_data, 8'hxx);
            else chk("tx_data", tx_data, exp_tx.pop_front());
            tx_busy  = 1'b1;
            busy_cnt = 5;
        end
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        if (ap_start && !start_prev) begin
            hls_phase = 1;
            hcnt      = 0;
        end
        start_prev = ap_start;
        if (hls_phase == 1) begin
            if (hcnt == ready_dly) begin
                ap_ready = 1'b1;
                if (same_cycle) begin
                    ap_done   = 1'b1;
                    ap_return = ret_val;
                    hls_phase = 0;
                end else begin
                    hls_phase = 2;
                    hcnt      = 0;
                end
            end else begin
                hcnt++;
            end
        end else if (hls_phase == 2) begin
            hcnt++;
            if (done_dly >= 0 && hcnt == done_dly) begin
                ap_done   = 1'b1;
                ap_return = ret_val;
                hls_phase = 0;
            end
        end
    end

    // Reference model: display gets the whole value, UART gets bytes MSB first.
    task automatic expect_result(input bit mode, input logic [31:0] v);
        if (!mode) exp_disp.push_back(v);
        else for (int b = 3; b >= 0; b--) exp_tx.push_back(8'((v >> (8 * b)) & 32'hFF));
    endtask

    task automatic issue_cmd(input bit c, input bit m);
        cmd_ready = 1'b1;
        cmd       = c;
        out_mode  = m;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk(name, done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_txn(input bit c, input bit m, input logic [31:0] v, input int rd, input int dd);
        ready_dly = rd;
        done_dly  = dd;
        ret_val   = v;
        expect_result(m, v);
        issue_cmd(c, m);
        chk("hls_op_latched", hls_op, c);
        wait_idle("txn_complete", 400);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", bram_grant_hls, 0);
        chk("rst_ap_start", ap_start, 0);
        chk("rst_outputs", {tx_data, tx_start, disp_value, disp_valid, err_timeout, cmd_dropped, hls_op}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Display path with directed latencies.
        ready_dly = 3; done_dly = 7; ret_val = 32'h0000_1234;
        expect_result(0, 32'h0000_1234);
        issue_cmd(0, 0);
        chk("grant_in_grant", bram_grant_hls, 1);
        chk("no_start_in_grant", ap_start, 0);
        chk("busy_in_grant", busy, 1);
        chk("hls_op_disp", hls_op, 0);
        @(negedge clk);
        chk("ap_start_in_start", ap_start, 1);
        wait_idle("disp_complete", 100);
        chk("disp_value_held", disp_value, 32'h0000_1234);
        chk("grant_released", bram_grant_hls, 0);

        // UART path directed then randomized.
        run_txn(1, 1, 32'hDEAD_BEEF, 2, 4);
        for (int i = 0; i < 6; i++)
            run_txn(1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(1, 20));

        // Load interlock.
        disable_screen = 1'b1;
        issue_cmd(1, 1);
        chk("drop_while_loading", cmd_dropped, 1);
        chk("idle_while_loading", busy, 0);
        chk("grant_while_loading", bram_grant_hls, 0);
        @(negedge clk);
        chk("drop_is_pulse", cmd_dropped, 0);
        disable_screen = 1'b0;
        run_txn(0, 0, 32'hCAFE_0001, 1, 3);

        // Watchdog abort after 64 cycles in START/WAIT.
        ready_dly = 2; done_dly = -1;
        issue_cmd(1, 0);
        @(negedge clk);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 63) begin
                chk("wd_not_yet", err_timeout, 0);
                chk("wd_busy_before", busy, 1);
            end
        end
        chk("wd_err_timeout", err_timeout, 1);
        chk("wd_ap_start", ap_start, 0);
        chk("wd_grant", bram_grant_hls, 0);
        chk("wd_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("wd_err_sticky", err_timeout, 1);
        ready_dly = 1; done_dly = 2; ret_val = 32'h55;
        expect_result(0, 32'h55);
        issue_cmd(0, 0);
        chk("wd_err_cleared", err_timeout, 0);
        wait_idle("wd_recover_complete", 100);

        // Same-cycle ready and done.
        same_cycle = 1;
        run_txn(0, 0, 32'd7, 2, 0);
        same_cycle = 0;

        // Command during WAIT is dropped; mode and op keep their latched values.
        ready_dly = 1; done_dly = 10; ret_val = 32'h0BAD_F00D;
        expect_result(0, 32'h0BAD_F00D);
        issue_cmd(1, 0);
        repeat (5) @(negedge clk);
        issue_cmd(0, 1);
        chk("drop_in_wait", cmd_dropped, 1);
        chk("hls_op_kept", hls_op, 1);
        wait_idle("wait_drop_complete", 100);

        // Async reset while waiting on byte 2 of 4.
        ready_dly = 1; done_dly = 2; ret_val = 32'h1122_3344;
        expect_result(1, 32'h1122_3344);
        tx_count = 0;
        issue_cmd(1, 1);
        begin
            bit seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                #1;
                if (tx_count == 3) seen = 1;
            end
            chk("reached_byte2", seen, 1);
        end
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_grant_start", {bram_grant_hls, ap_start}, 0);
        chk("arst_outputs", {tx_data, tx_start, disp_value, disp_valid, err_timeout, cmd_dropped, hls_op}, 0);
        exp_tx.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("arst_no_more_tx", tx_count, 3);
        chk("arst_idle", busy, 0);

        chk("disp_queue_drained", exp_disp.size(), 0);
        chk("tx_queue_drained", exp_tx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/coproc_sequencer.md
Name: coproc_sequencer

Overview:
- Top-level controller for the vector coprocessor.
- Accepts decoded host commands (cmd, out_mode, cmd_ready, disable_screen) from the UART command decoder.
- Hands BRAM ownership to the HLS core, runs one ap_start/ap_done transaction, then routes the scalar result to the 7-segment display register or back to the host as UART bytes.
- Also owns a watchdog that aborts a hung HLS core.

Parameters:
- RESULT_W, 32, width of HLS ap_return and result register; must equal 8*TX_BYTES.
- TX_BYTES, 4, bytes sent to UART per result, MSB first.
- TIMEOUT_CYCLES, 1048576, cycles from START entry before abort; counter width clog2(TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_ready  in  1  one-cycle pulse: new command decoded
- cmd  in  1  operation select, forwarded to HLS (0 = dot product, 1 = Euclidean distance)
- out_mode  in  1  result destination (0 = display, 1 = UART)
- disable_screen  in  1  high while host is writing vector data into BRAM
- bram_grant_hls  out  1  1 = HLS core drives both BRAM ports; 0 = UART loader drives them
- hls_op  out  1  latched cmd, stable for the whole transaction
- ap_start  out  1  HLS start
- ap_ready  in  1  HLS has accepted inputs
- ap_done  in  1  HLS result valid (one-cycle pulse)
- ap_return  in  RESULT_W  HLS result
- tx_data  out  8  byte to UART transmitter
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  UART transmitter busy
- disp_value  out  RESULT_W  value shown on display, held until next display result
- disp_valid  out  1  one-cycle pulse when disp_value updates
- busy  out  1  high in any state except IDLE
- err_timeout  out  1  sticky watchdog abort flag
- cmd_dropped  out  1  one-cycle pulse when cmd_ready is ignored

Behaviour:
Reset:
- All outputs 0; state = IDLE.
- Reset is asynchronous: ap_start and bram_grant_hls fall immediately when rst_n asserts, including mid-transaction.

States: IDLE, GRANT, START, WAIT, OUT_DISP, TX_SEND, TX_GAP, TX_WAIT.

IDLE:
- cmd_ready=1 and disable_screen=0: latch cmd->hls_op, out_mode->mode_q; clear err_timeout; clear watchdog; go to GRANT.
- cmd_ready=1 and disable_screen=1: ignored, cmd_dropped pulses.

GRANT:
- bram_grant_hls=1 from this cycle onward (one settle cycle for the BRAM mux); go to START.

START:
- ap_start=1, held until ap_ready is sampled 1.
- On ap_ready: ap_start=0 next cycle; go to WAIT.
- If ap_done=1 in the same cycle as ap_ready: capture ap_return immediately and skip WAIT.

WAIT:
- On ap_done=1: result_q<=ap_return; bram_grant_hls=0 next cycle.
- Then go to OUT_DISP if mode_q=0, else to TX_SEND with byte index 0.

Watchdog:
- Increments every cycle in START and WAIT.
- At TIMEOUT_CYCLES-1 without ap_done: err_timeout=1, ap_start=0, bram_grant_hls=0, go to IDLE. No output is produced.

OUT_DISP:
- disp_value<=result_q, disp_valid=1 for one cycle; go to IDLE.

TX_SEND:
- Wait until tx_busy=0, then tx_start=1 for one cycle.
- tx_data = result_q byte (TX_BYTES-1-idx), so byte 0 sent is bits [RESULT_W-1:RESULT_W-8]. tx_data is held until the next TX_SEND.
- Go to TX_GAP.

TX_GAP:
- One cycle; tx_busy is ignored so the transmitter can raise it. Go to TX_WAIT.

TX_WAIT:
- When tx_busy=0: if idx=TX_BYTES-1, go to IDLE; else idx++ and go to TX_SEND.

Other rules:
- cmd_ready in any non-IDLE state: ignored, cmd_dropped pulses, latched hls_op/mode_q unchanged.
- busy is combinational from state (state != IDLE).
- ap_done while in IDLE or GRANT is ignored.

Test Plan:
- Display path: cmd_ready, cmd=0, out_mode=0; ap_ready after 3 cycles, ap_done with ap_return=0x0000_1234 after 10 -> hls_op=0, grant high GRANT..WAIT, ap_start drops the cycle after ap_ready, disp_value=0x1234 with one disp_valid pulse, busy falls, no tx_start.
- UART path: out_mode=1, ap_return=0xDEADBEEF, tx_busy high 5 cycles after each tx_start -> exactly 4 tx_start pulses with tx_data DE, AD, BE, EF; no new tx_start while tx_busy=1.
- Load interlock: cmd_ready while disable_screen=1 -> cmd_dropped pulse, state stays IDLE, grant 0; cmd_ready again after disable_screen=0 -> accepted.
- Watchdog: TIMEOUT_CYCLES=64, ap_done never asserted -> err_timeout=1 at cycle 63 after START entry, ap_start=0, grant=0, IDLE; next accepted cmd_ready clears err_timeout.
- Same-cycle handshake: ap_ready and ap_done asserted together with ap_return=7 -> result captured, WAIT skipped, disp_value=7. Also cmd_ready during WAIT -> cmd_dropped pulse, hls_op unchanged.
- Async reset during TX_WAIT (byte 2 of 4) -> all outputs 0 immediately without a clock edge, IDLE after release, no further tx_start.
